// File: rtl/register_file.sv
// rtl/register_file.sv - 2**AW x XLEN register file, two combinational read ports, write-first bypass
module register_file #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wdata,
  input  logic            RegWrite,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en_d;

  // A write is live only outside reset and never to register 0
  always_comb begin
    wr_en_d = RegWrite && !rst && (rd != '0);
  end

  // Storage: async clear of the whole array, single full-width write per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[rd] <= wdata;
    end
  end

  // Read port 1: forced 0 in reset and for address 0, otherwise write-first bypass over storage
  always_comb begin
    rdata1 = '0;
    if (!rst && (rs1 != '0)) begin
      if (wr_en_d && (rs1 == rd)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs_q[rs1];
      end
    end
  end

  // Read port 2: identical behaviour, independent address
  always_comb begin
    rdata2 = '0;
    if (!rst && (rs2 != '0)) begin
      if (wr_en_d && (rs2 == rd)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wdata;
  logic            RegWrite;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  int checks;
  int errors;

  register_file #(.XLEN(XLEN), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .wdata    (wdata),
    .RegWrite (RegWrite),
    .rdata1   (rdata1),
    .rdata2   (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one write, let the rising edge take it, then drop the enable
  task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rd       = a;
    wdata    = d;
    RegWrite = 1'b1;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    wdata    = '0;
    RegWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Post-reset sweep: every address reads 0 on both ports
    for (int a = 0; a < 32; a++) begin
      rs1 = a[AW-1:0];
      rs2 = a[AW-1:0];
      #1;
      check($sformatf("reset_sweep_rd1[%0d]", a), rdata1, '0);
      check($sformatf("reset_sweep_rd2[%0d]", a), rdata2, '0);
    end

    // Fill 1..30 with their own index, read back k and k-1
    for (int k = 1; k <= 30; k++) begin
      do_write(k[AW-1:0], 64'(k));
      rs1 = k[AW-1:0];
      rs2 = 5'(k - 1);
      #1;
      check($sformatf("fill_rd1[%0d]", k), rdata1, 64'(k));
      check($sformatf("fill_rd2[%0d]", k), rdata2, 64'(k - 1));
    end

    // Write to register 0 is discarded and never bypassed
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    wdata    = 64'hDEAD_BEEF;
    RegWrite = 1'b1;
    #1;
    check("r0_before_edge", rdata1, '0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("r0_after_edge", rdata1, '0);

    // Bypass: reg5 holds 5, pending write of 0x1234 must be seen before the edge
    rs1      = 5'd5;
    rs2      = 5'd4;
    rd       = 5'd5;
    wdata    = 64'h1234;
    RegWrite = 1'b1;
    #1;
    check("bypass_rd1", rdata1, 64'h1234);
    check("bypass_other_port", rdata2, 64'd4);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    wdata    = 64'h0;
    #1;
    check("bypass_after_edge", rdata1, 64'h1234);

    // All-ones in reg7 holds while wdata wiggles with RegWrite=0
    do_write(5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    rs1 = 5'd7;
    rs2 = 5'd7;
    rd  = 5'd7;
    for (int i = 0; i < 3; i++) begin
      wdata = 64'h0123_4567_89AB_CDEF + 64'(i);
      @(posedge clk);
      #1;
      check($sformatf("hold_rd1[%0d]", i), rdata1, 64'hFFFF_FFFF_FFFF_FFFF);
      check($sformatf("hold_rd2[%0d]", i), rdata2, 64'hFFFF_FFFF_FFFF_FFFF);
    end

    // Complete the fill with reg31
    do_write(5'd31, 64'h3131_3131);
    rs1 = 5'd31;
    rs2 = 5'd30;
    #1;
    check("fill_r31", rdata1, 64'h3131_3131);

    // Asynchronous reset between edges clears outputs immediately
    rs1 = 5'd31;
    rs2 = 5'd7;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rd1", rdata1, '0);
    check("async_rst_rd2", rdata2, '0);

    // In reset: bypass disabled and a write edge is lost
    rs1      = 5'd12;
    rd       = 5'd12;
    wdata    = 64'hAAAA_5555;
    RegWrite = 1'b1;
    #1;
    check("rst_no_bypass", rdata1, '0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst_write_lost", rdata1, '0);

    // First write after reset works; every other register is cleared
    do_write(5'd3, 64'd9);
    for (int a = 0; a < 32; a++) begin
      rs1 = a[AW-1:0];
      rs2 = 5'(31 - a);
      #1;
      check($sformatf("post_rst_rd1[%0d]", a), rdata1, (a == 3) ? 64'd9 : 64'd0);
      check($sformatf("post_rst_rd2[%0d]", a), rdata2, ((31 - a) == 3) ? 64'd9 : 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
